// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I (optional RV32M) decode pipeline stage.
//
// Takes one instruction beat per accept, decodes it into a 15-bit control
// bus plus M-extension / illegal flags, and presents the registered result
// downstream under a valid/ready handshake. A saturating counter tracks
// how many illegal instructions have been accepted.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_instr, in_pc     instruction word and its address
//   flush               synchronous kill of the stage (discards in-flight beat)
//   out_valid/out_ready downstream handshake
//   out_pc, out_rd, out_rs1, out_rs2   registered address and register fields
//   out_ctrl            {reg_write, imm_src[2:0], alu_src, alu_op, alu_add,
//                        store_op, load_op, result_src, pc_to_rd[1:0],
//                        pc_src[1:0], branch}
//   out_mul, out_illegal  registered M-extension / illegal flags
//   ill_clr, ill_count  clear and value of the saturating illegal counter
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [14:0]      out_ctrl,
    output logic             out_mul,
    output logic             out_illegal,
    input  logic             ill_clr,
    output logic [CNT_W-1:0] ill_count
);

    localparam logic [14:0] CTRL_R      = 15'b100000000000000;
    localparam logic [14:0] CTRL_I_SH   = 15'b110110000000000;
    localparam logic [14:0] CTRL_I_ALU  = 15'b100011000000000;
    localparam logic [14:0] CTRL_STORE  = 15'b000110110000000;
    localparam logic [14:0] CTRL_LOAD   = 15'b100010101100000;
    localparam logic [14:0] CTRL_BRANCH = 15'b001000000000011;
    localparam logic [14:0] CTRL_JALR   = 15'b100010100001100;
    localparam logic [14:0] CTRL_JAL    = 15'b110000000001010;
    localparam logic [14:0] CTRL_LUI    = 15'b101100000010000;
    localparam logic [14:0] CTRL_AUIPC  = 15'b101100000011000;
    localparam logic [14:0] CTRL_NONE   = 15'b000000000000000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Decode one instruction word into {illegal, mul, ctrl[14:0]}.
    function automatic logic [16:0] decode_f(input logic [31:0] instr);
        logic [14:0] ctrl;
        logic        mul;
        logic        ill;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        ctrl   = CTRL_NONE;
        mul    = 1'b0;
        ill    = 1'b0;
        funct3 = instr[14:12];
        funct7 = instr[31:25];
        case (instr[6:0])
            7'b0110011: begin
                if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) begin
                    ctrl = CTRL_R;
                end else if ((EN_M == 1) && (funct7 == 7'b0000001)) begin
                    ctrl = CTRL_R;
                    mul  = 1'b1;
                end else begin
                    ill  = 1'b1;
                end
            end
            7'b0010011: begin
                // Shifts carry a shamt immediate, other ALU-imm ops a plain I-imm.
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    ctrl = CTRL_I_SH;
                end else begin
                    ctrl = CTRL_I_ALU;
                end
            end
            7'b0100011: ctrl = CTRL_STORE;
            7'b0000011: ctrl = CTRL_LOAD;
            7'b1100011: ctrl = CTRL_BRANCH;
            7'b1100111: ctrl = CTRL_JALR;
            7'b1101111: ctrl = CTRL_JAL;
            7'b0110111: ctrl = CTRL_LUI;
            7'b0010111: ctrl = CTRL_AUIPC;
            7'b0001111: ctrl = CTRL_NONE;
            7'b1110011: ctrl = CTRL_NONE;
            default:    ill  = 1'b1;
        endcase
        // Compressed / non-32-bit encodings are never decoded.
        if (instr[1:0] != 2'b11) begin
            ctrl = CTRL_NONE;
            mul  = 1'b0;
            ill  = 1'b1;
        end else begin
            ill  = ill;
        end
        return {ill, mul, ctrl};
    endfunction

    logic             out_valid_r;
    logic [XLEN-1:0]  out_pc_r;
    logic [4:0]       out_rd_r;
    logic [4:0]       out_rs1_r;
    logic [4:0]       out_rs2_r;
    logic [14:0]      out_ctrl_r;
    logic             out_mul_r;
    logic             out_illegal_r;
    logic [CNT_W-1:0] ill_count_r;

    logic             in_ready_s;
    logic             accept_s;
    logic [16:0]      dec_s;
    logic             ill_inc_s;

    // Handshake and decode of the current input word.
    always_comb begin
        in_ready_s = (!out_valid_r) || out_ready || flush;
        accept_s   = in_valid && in_ready_s;
        dec_s      = decode_f(in_instr);
        ill_inc_s  = accept_s && (!flush) && dec_s[16] && (ill_count_r != CNT_MAX);
    end

    // Output register: flush wins, then accept, then drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_pc_r      <= {XLEN{1'b0}};
            out_rd_r      <= 5'd0;
            out_rs1_r     <= 5'd0;
            out_rs2_r     <= 5'd0;
            out_ctrl_r    <= 15'd0;
            out_mul_r     <= 1'b0;
            out_illegal_r <= 1'b0;
        end else if (flush) begin
            out_valid_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_pc_r      <= in_pc;
            out_rd_r      <= in_instr[11:7];
            out_rs1_r     <= in_instr[19:15];
            out_rs2_r     <= in_instr[24:20];
            out_ctrl_r    <= dec_s[14:0];
            out_mul_r     <= dec_s[15];
            out_illegal_r <= dec_s[16];
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    // Saturating illegal-instruction counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_count_r <= {CNT_W{1'b0}};
        end else if (ill_clr) begin
            ill_count_r <= {CNT_W{1'b0}};
        end else if (ill_inc_s) begin
            ill_count_r <= ill_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ill_count_r <= ill_count_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_pc      = out_pc_r;
    assign out_rd      = out_rd_r;
    assign out_rs1     = out_rs1_r;
    assign out_rs2     = out_rs2_r;
    assign out_ctrl    = out_ctrl_r;
    assign out_mul     = out_mul_r;
    assign out_illegal = out_illegal_r;
    assign ill_count   = ill_count_r;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, sets the PC width; legal values are 32 and 64.
REQ-002 Parameter EN_M, default 0; when set to 1, RV32M decode is enabled.
REQ-003 Parameter CNT_W, default 8, sets the width of the illegal-instruction counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  the upstream beat is valid.
REQ-007 in_ready  out  1  the stage can accept a beat.
REQ-008 in_instr  in  32  instruction word.
REQ-009 in_pc  in  XLEN  instruction address.
REQ-010 flush  in  1  synchronous pipeline kill.
REQ-011 out_valid  out  1  the decoded beat is valid.
REQ-012 out_ready  in  1  downstream accepts the beat.
REQ-013 out_pc  out  XLEN  registered copy of in_pc.
REQ-014 out_rd, out_rs1, out_rs2  out  5 each  registered instr[11:7], instr[19:15] and instr[24:20].
REQ-015 out_ctrl  out  15  control bus {reg_write, imm_src[2:0], alu_src, alu_op, alu_add, store_op, load_op, result_src, pc_to_rd[1:0], pc_src[1:0], branch}, MSB first.
REQ-016 out_mul  out  1  the beat is an M-extension operation.
REQ-017 out_illegal  out  1  the beat is an illegal instruction.
REQ-018 ill_clr  in  1  synchronous clear of ill_count.
REQ-019 ill_count  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-020 in_ready SHALL equal (!out_valid || out_ready || flush), combinationally.
REQ-021 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-022 An accepted beat with flush=0 SHALL load all out_* registers and set out_valid=1 one cycle later (latency 1).
REQ-023 With no accept and out_ready=1, out_valid SHALL clear; with out_ready=0, all out_* SHALL hold stable.
REQ-024 When flush=1, out_valid SHALL be 0 next cycle and the beat accepted in that cycle SHALL be discarded; flush overrides all other updates.
REQ-025 out_ctrl SHALL decode by opcode (instr[6:0]) as follows:
- 0110011 gives 100000000000000.
- 0010011 with funct3 001 or 101 gives 110110000000000; other funct3 give 100011000000000.
- 0100011 gives 000110110000000.
- 0000011 gives 100010101100000.
- 1100011 gives 001000000000011.
- 1100111 gives 100010100001100.
- 1101111 gives 110000000001010.
- 0110111 gives 101100000010000.
- 0010111 gives 101100000011000.
REQ-026 Opcode 0110011 with funct7=0000001 SHALL set out_mul=1 and use the R-type out_ctrl when EN_M=1, and SHALL be illegal when EN_M=0.
REQ-027 For 0110011 with EN_M=0, funct7 SHALL be 0000000 or 0100000, otherwise illegal; with EN_M=1 only those two values and 0000001 are legal.
REQ-028 Opcodes 0001111 (FENCE) and 1110011 (SYSTEM) SHALL decode as legal with out_ctrl=0 and out_mul=0.
REQ-029 Any other opcode, or instr[1:0]!=2'b11, SHALL give out_illegal=1, out_ctrl=0 and out_mul=0.
REQ-030 out_illegal SHALL be computed from the same accepted instr as out_ctrl and registered with it.
REQ-031 ill_count SHALL increment by 1 per accepted, non-flushed illegal beat and saturate at 2^CNT_W-1 with no wrap-around.
REQ-032 When ill_clr and an increment occur in the same cycle, ill_clr SHALL win and ill_count SHALL be 0.
REQ-033 Decoding SHALL have no dependency on XLEN other than the width of out_pc.

Reset
REQ-034 While rst_n=0, out_valid, out_ctrl, out_mul, out_illegal, out_rd, out_rs1, out_rs2, out_pc and ill_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-035 in_ready SHALL be 1 during reset and on the first cycle after release.
REQ-036 Reset asserted mid-transfer SHALL drop the pending out beat.

Verification
REQ-037 Input beat instr=0x00500093 (addi x1,x0,5) with out_ready=1 -> one cycle later out_valid=1, out_ctrl=100011000000000, out_rd=1, out_illegal=0.
REQ-038 Input beat instr=0x02B50533 (mul) -> EN_M=0 gives out_illegal=1 and ill_count=1; EN_M=1 gives out_mul=1 and out_ctrl=100000000000000.
REQ-039 Hold out_ready=0 for 3 cycles with a beat held -> out_* stable, in_ready=0; then raise out_ready -> next beat accepted in that same cycle.
REQ-040 Assert flush in the cycle a JAL (0x008000EF) is accepted -> out_valid=0 next cycle and ill_count unchanged.
REQ-041 With CNT_W=2, send 5 illegal words (0x00000000) -> ill_count reads 1,2,3,3,3; assert ill_clr together with a 6th illegal word -> ill_count=0.
REQ-042 Drop rst_n asynchronously while out_valid=1 -> out_valid=0 before the next edge, and a later beat decodes normally.
